signed_binary_to_bcd: RTL and testbench

SIGNED_BINARY_TO_BCD -- requirements
Module: signed_binary_to_bcd

---
 rtl/signed_binary_to_bcd.sv | 151 +++++++++++++++
 tb/tb_signed_binary_to_bcd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_binary_to_bcd.sv
// Sequential signed/unsigned binary to BCD converter (shift-add-3), one magnitude
// bit per clock, with saturation on overflow and a leading-zero blank mask.
module signed_binary_to_bcd #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5,
    parameter int SIGNED         = 1
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic [INPUT_WIDTH-1:0]        i_Binary,
    input  logic                          i_Start,
    output logic                          o_Busy,
    output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
    output logic                          o_Negative,
    output logic [DECIMAL_DIGITS-1:0]     o_Blank,
    output logic                          o_Overflow,
    output logic                          o_DV
);

    localparam int unsigned NDIG = DECIMAL_DIGITS;
    localparam int          BW   = DECIMAL_DIGITS * 4;
    localparam int          CW   = $clog2(INPUT_WIDTH);

    localparam logic [CW-1:0]             LAST_BIT  = CW'(INPUT_WIDTH - 1);
    localparam logic [BW-1:0]             ALL_NINES = {DECIMAL_DIGITS{4'h9}};
    localparam logic [DECIMAL_DIGITS-1:0] BLANK_RST = ~DECIMAL_DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [INPUT_WIDTH-1:0]    mag_q, mag_d;
    logic                      sign_q, sign_d;
    logic [BW-1:0]             work_q, work_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic [BW-1:0]             bcd_q, bcd_d;
    logic                      neg_q, neg_d;
    logic [DECIMAL_DIGITS-1:0] blank_q, blank_d;
    logic                      ovf_out_q, ovf_out_d;
    logic                      dv_q, dv_d;

    logic                      neg_in;
    logic [INPUT_WIDTH-1:0]    mag_in;
    logic [BW-1:0]             adj;
    logic [BW-1:0]             result;
    logic [DECIMAL_DIGITS-1:0] blank_new;
    logic                      zero_run;

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        blank_d   = blank_q;
        ovf_out_d = ovf_out_q;
        dv_d      = 1'b0;

        neg_in = (SIGNED != 0) && i_Binary[INPUT_WIDTH-1];
        mag_in = neg_in ? (~i_Binary + INPUT_WIDTH'(1)) : i_Binary;

        adj = work_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (work_q[4*i +: 4] > 4'd4)
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end

        result = ovf_q ? ALL_NINES : work_q;

        // Scan from the top digit down; digit 0 is never blanked.
        blank_new = '0;
        zero_run  = 1'b1;
        for (int unsigned i = 0; i + 1 < NDIG; i++) begin
            zero_run = zero_run & (result[4*(NDIG-1-i) +: 4] == 4'd0);
            blank_new[NDIG-1-i] = zero_run;
        end

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    sign_d  = neg_in;
                    mag_d   = mag_in;
                    work_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                work_d = {adj[BW-2:0], mag_q[INPUT_WIDTH-1]};
                ovf_d  = ovf_q | adj[BW-1];
                mag_d  = {mag_q[INPUT_WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT)
                    state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d     = result;
                neg_d     = sign_q;
                blank_d   = blank_new;
                ovf_out_d = ovf_q;
                dv_d      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            blank_q   <= BLANK_RST;
            ovf_out_q <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            blank_q   <= blank_d;
            ovf_out_q <= ovf_out_d;
            dv_q      <= dv_d;
        end
    end

    assign o_Busy     = (state_q == S_CONVERT) || (state_q == S_DONE);
    assign o_BCD      = bcd_q;
    assign o_Negative = neg_q;
    assign o_Blank    = blank_q;
    assign o_Overflow = ovf_out_q;
    assign o_DV       = dv_q;

endmodule

// File: tb/tb_signed_binary_to_bcd.sv
// Directed bench: three converter configurations share clock, reset and stimulus;
// each result is compared against hand-computed decimal values.
module tb_signed_binary_to_bcd;

    logic        clk;
    logic        rst_n;
    logic [15:0] bin;
    logic        start;

    logic        busy_a, neg_a, ovf_a, dv_a;
    logic [19:0] bcd_a;
    logic [4:0]  blank_a;
    logic        busy_b, neg_b, ovf_b, dv_b;
    logic [11:0] bcd_b;
    logic [2:0]  blank_b;
    logic        busy_c, neg_c, ovf_c, dv_c;
    logic [19:0] bcd_c;
    logic [4:0]  blank_c;

    int n_checks = 0;
    int n_pass   = 0;

    signed_binary_to_bcd #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED(1)) u_dut_a (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Binary(bin), .i_Start(start),
        .o_Busy(busy_a), .o_BCD(bcd_a), .o_Negative(neg_a), .o_Blank(blank_a),
        .o_Overflow(ovf_a), .o_DV(dv_a)
    );

    signed_binary_to_bcd #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(3), .SIGNED(1)) u_dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Binary(bin), .i_Start(start),
        .o_Busy(busy_b), .o_BCD(bcd_b), .o_Negative(neg_b), .o_Blank(blank_b),
        .o_Overflow(ovf_b), .o_DV(dv_b)
    );

    signed_binary_to_bcd #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED(0)) u_dut_c (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Binary(bin), .i_Start(start),
        .o_Busy(busy_c), .o_BCD(bcd_c), .o_Negative(neg_c), .o_Blank(blank_c),
        .o_Overflow(ovf_c), .o_DV(dv_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [15:0] in;
        logic [19:0] a_bcd;
        logic        a_neg;
        logic [4:0]  a_blank;
        logic        a_ovf;
        logic [11:0] b_bcd;
        logic        b_neg;
        logic [2:0]  b_blank;
        logic        b_ovf;
        logic [19:0] c_bcd;
        logic [4:0]  c_blank;
    } vec_t;

    vec_t vecs[10] = '{
        '{16'h3039, 20'h12345, 1'b0, 5'b00000, 1'b0, 12'h999, 1'b0, 3'b000, 1'b1, 20'h12345, 5'b00000},
        '{16'h8000, 20'h32768, 1'b1, 5'b00000, 1'b0, 12'h999, 1'b1, 3'b000, 1'b1, 20'h32768, 5'b00000},
        '{16'h0000, 20'h00000, 1'b0, 5'b11110, 1'b0, 12'h000, 1'b0, 3'b110, 1'b0, 20'h00000, 5'b11110},
        '{16'h03E8, 20'h01000, 1'b0, 5'b10000, 1'b0, 12'h999, 1'b0, 3'b000, 1'b1, 20'h01000, 5'b10000},
        '{16'hFFF9, 20'h00007, 1'b1, 5'b11110, 1'b0, 12'h007, 1'b1, 3'b110, 1'b0, 20'h65529, 5'b00000},
        '{16'hFFFF, 20'h00001, 1'b1, 5'b11110, 1'b0, 12'h001, 1'b1, 3'b110, 1'b0, 20'h65535, 5'b00000},
        '{16'h03E7, 20'h00999, 1'b0, 5'b11000, 1'b0, 12'h999, 1'b0, 3'b000, 1'b0, 20'h00999, 5'b11000},
        '{16'h7FFF, 20'h32767, 1'b0, 5'b00000, 1'b0, 12'h999, 1'b0, 3'b000, 1'b1, 20'h32767, 5'b00000},
        '{16'h0063, 20'h00099, 1'b0, 5'b11100, 1'b0, 12'h099, 1'b0, 3'b100, 1'b0, 20'h00099, 5'b11100},
        '{16'h8001, 20'h32767, 1'b1, 5'b00000, 1'b0, 12'h999, 1'b1, 3'b000, 1'b1, 20'h32769, 5'b00000}
    };

    // Returns edges from acceptance to o_DV on instance A, or -1 if it never came.
    task automatic wait_dv(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (dv_a) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic convert(input logic [15:0] v, output int lat);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 16'($urandom);
        check("busy_after_start", busy_a, 1'b1);
        wait_dv(lat);
    endtask

    initial begin
        int lat;
        int ndv;
        logic [19:0] got;

        rst_n = 1'b1;
        start = 1'b0;
        bin   = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",  busy_a,  1'b0);
        check("rst_dv",    dv_a,    1'b0);
        check("rst_bcd",   bcd_a,   20'h0);
        check("rst_neg",   neg_a,   1'b0);
        check("rst_ovf",   ovf_a,   1'b0);
        check("rst_blank", blank_a, 5'b11110);
        check("rst_blank_b", blank_b, 3'b110);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            convert(vecs[i].in, lat);
            check("latency",  lat, 17);
            check("a_bcd",    bcd_a,   vecs[i].a_bcd);
            check("a_neg",    neg_a,   vecs[i].a_neg);
            check("a_blank",  blank_a, vecs[i].a_blank);
            check("a_ovf",    ovf_a,   vecs[i].a_ovf);
            check("b_dv",     dv_b,    1'b1);
            check("b_bcd",    bcd_b,   vecs[i].b_bcd);
            check("b_neg",    neg_b,   vecs[i].b_neg);
            check("b_blank",  blank_b, vecs[i].b_blank);
            check("b_ovf",    ovf_b,   vecs[i].b_ovf);
            check("c_dv",     dv_c,    1'b1);
            check("c_bcd",    bcd_c,   vecs[i].c_bcd);
            check("c_neg",    neg_c,   1'b0);
            check("c_blank",  blank_c, vecs[i].c_blank);
            check("c_ovf",    ovf_c,   1'b0);
            check("idle_at_dv", busy_a, 1'b0);
            @(posedge clk);
            #1;
            check("dv_one_cycle", dv_a, 1'b0);
            check("held_bcd",     bcd_a, vecs[i].a_bcd);
        end

        // Start held high through the whole conversion, including the DONE cycle.
        @(negedge clk);
        bin   = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        bin = 16'h1234;
        ndv = 0;
        got = '0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (dv_a) begin
                ndv++;
                got = bcd_a;
            end
        end
        check("busy_start_ndv", ndv, 1);
        check("busy_start_bcd", got, 20'h00001);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_busy", busy_a, 1'b1);
        wait_dv(lat);
        check("restart_latency", lat, 17);
        check("restart_bcd", bcd_a, 20'h04660);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin   = 16'h3039;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",  busy_a,  1'b0);
        check("midrst_dv",    dv_a,    1'b0);
        check("midrst_bcd",   bcd_a,   20'h0);
        check("midrst_neg",   neg_a,   1'b0);
        check("midrst_ovf",   ovf_a,   1'b0);
        check("midrst_blank", blank_a, 5'b11110);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndv = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (dv_a) ndv++;
        end
        check("midrst_no_dv", ndv, 0);
        convert(16'h0063, lat);
        check("postrst_latency", lat, 17);
        check("postrst_bcd",   bcd_a,   20'h00099);
        check("postrst_blank", blank_a, 5'b11100);
        check("postrst_neg",   neg_a,   1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
